// File: rtl/spi_echo_slave.sv
// Oversampled SPI mode-0 slave: echoes each received byte on MISO during the next byte
// and reports received bytes and a wrapping byte count, all in the CLK domain.
module spi_echo_slave #(
  parameter logic [7:0] RESET_BYTE  = 8'h3C,
  parameter logic       IDLE_MISO   = 1'b0,
  parameter int         COUNT_W     = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               resetn,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_cs,
  output logic               spi_miso,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic [COUNT_W-1:0] byte_count,
  output logic               busy
);

  localparam int SL = SYNC_STAGES - 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  logic [SL:0]        sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic               sclk_prev_q, cs_prev_q;
  logic               sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q, mosi_q;

  state_e             state_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         rx_shift_q, tx_shift_q, tx_byte_q, rx_data_q;
  logic               valid_pend_q, rx_valid_q, miso_q, busy_q;
  logic [COUNT_W-1:0] byte_count_q;
  logic [7:0]         rx_byte_d;

  assign rx_byte_d = {rx_shift_q[6:0], mosi_q};

  // Synchronise the SPI pins and register edge pulses aligned with the sampled MOSI bit
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SL-1:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SL-1:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SL-1:0], spi_cs};
      sclk_prev_q <= sclk_sync_q[SL];
      cs_prev_q   <= cs_sync_q[SL];
      sclk_rise_q <= sclk_sync_q[SL] & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_sync_q[SL] & sclk_prev_q;
      cs_rise_q   <= cs_sync_q[SL] & ~cs_prev_q;
      cs_fall_q   <= ~cs_sync_q[SL] & cs_prev_q;
      mosi_q      <= mosi_sync_q[SL];
    end
  end

  // Transfer FSM with registered outputs; a completed byte is published one cycle after capture
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 8'h00;
      tx_shift_q   <= 8'h00;
      tx_byte_q    <= RESET_BYTE;
      rx_data_q    <= 8'h00;
      valid_pend_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      miso_q       <= IDLE_MISO;
      busy_q       <= 1'b0;
      byte_count_q <= '0;
    end else begin
      rx_valid_q   <= valid_pend_q;
      valid_pend_q <= 1'b0;
      if (valid_pend_q) begin
        rx_data_q    <= rx_shift_q;
        byte_count_q <= byte_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
      case (state_q)
        ST_IDLE: begin
          miso_q <= IDLE_MISO;
          busy_q <= 1'b0;
          if (cs_fall_q) begin
            state_q    <= ST_ACTIVE;
            busy_q     <= 1'b1;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= tx_byte_q;
            miso_q     <= tx_byte_q[7];
          end
        end
        ST_ACTIVE: begin
          busy_q <= 1'b1;
          if (cs_rise_q) begin
            // Deselect wins over a coincident clock edge; a partial byte is dropped
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            miso_q    <= IDLE_MISO;
            bit_cnt_q <= 3'd0;
          end else if (sclk_rise_q) begin
            rx_shift_q <= rx_byte_d;
            if (bit_cnt_q == 3'd7) begin
              tx_byte_q    <= rx_byte_d;
              tx_shift_q   <= rx_byte_d;
              bit_cnt_q    <= 3'd0;
              valid_pend_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else if (sclk_fall_q) begin
            // Right after a byte boundary the freshly loaded MSB is presented unshifted
            if (bit_cnt_q == 3'd0) begin
              miso_q <= tx_shift_q[7];
            end else begin
              miso_q     <= tx_shift_q[6];
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          miso_q  <= IDLE_MISO;
        end
      endcase
    end
  end

  assign spi_miso   = miso_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign byte_count = byte_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_echo_slave.sv
// Randomised SPI master driving the echo slave, checked every cycle against a
// transaction-level model (bit counting, fixed latency, last-byte echo).
module tb_spi_echo_slave;
  localparam int S = 2;
  localparam int LAT = S + 3;  // drive cycle -> rx_valid cycle

  logic CLK = 1'b0, resetn = 1'b0, spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
  logic        spi_miso, rx_valid, busy;
  logic [7:0]  rx_data;
  logic [15:0] byte_count;
  logic        m4_miso, m4_valid, m4_busy;
  logic [7:0]  m4_data;
  logic [3:0]  m4_count;

  spi_echo_slave #(.COUNT_W(16), .SYNC_STAGES(S)) u_dut (
    .CLK(CLK), .resetn(resetn), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid), .byte_count(byte_count), .busy(busy));

  spi_echo_slave #(.COUNT_W(4), .SYNC_STAGES(S)) u_dut4 (
    .CLK(CLK), .resetn(resetn), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(m4_miso), .rx_data(m4_data), .rx_valid(m4_valid), .byte_count(m4_count), .busy(m4_busy));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, failures = 0, vpulses = 0, H = 8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { int at; logic [7:0] b; } pend_t;
  pend_t      m_pend[$];
  logic [7:0] m_last = 8'h3C, m_shift = 8'h00, m_data = 8'h00;
  int         m_bits = 0, m_count = 0;
  bit         m_hist[8];
  logic       m_prev_sclk = 1'b0, m_prev_cs = 1'b1;

  always @(negedge CLK) if (rx_valid) vpulses++;

  always @(negedge CLK) begin
    bit exp_valid;
    bit all_high;
    exp_valid = 1'b0;
    if (!resetn) begin
      m_last = 8'h3C; m_shift = 8'h00; m_data = 8'h00; m_bits = 0; m_count = 0;
      m_pend.delete();
      for (int i = 0; i < 8; i++) m_hist[i] = 1'b1;
      check("rst_miso", {31'd0, spi_miso}, 32'd0);
      check("rst_valid", {31'd0, rx_valid | m4_valid}, 32'd0);
      check("rst_count", {16'd0, byte_count}, 32'd0);
      check("rst_busy", {31'd0, busy | m4_busy}, 32'd0);
      check("rst_data", {24'd0, rx_data}, 32'd0);
    end else begin
      m_hist[cyc % 8] = spi_cs;
      if (spi_cs != m_prev_cs) m_bits = 0;
      if (spi_clk && !m_prev_sclk && !spi_cs) begin
        m_shift = {m_shift[6:0], spi_mosi};
        m_bits++;
        if (m_bits == 8) begin
          m_bits = 0;
          m_last = m_shift;
          m_pend.push_back('{cyc + LAT, m_shift});
        end
      end
      if (m_pend.size() > 0 && m_pend[0].at == cyc) begin
        exp_valid = 1'b1;
        m_data = m_pend[0].b;
        m_count++;
        void'(m_pend.pop_front());
      end
      check("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
      check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
      check("byte_count", {16'd0, byte_count}, m_count % 65536);
      check("count4_valid", {31'd0, m4_valid}, {31'd0, exp_valid});
      check("count4", {28'd0, m4_count}, m_count % 16);
      check("busy", {31'd0, busy}, {31'd0, ~m_hist[(cyc + 8 - (S + 2)) % 8]});
      all_high = 1'b1;
      for (int i = 0; i <= S + 2; i++) all_high &= m_hist[(cyc + 8 - i) % 8];
      if (all_high) check("idle_miso", {31'd0, spi_miso}, 32'd0);
    end
    m_prev_sclk = spi_clk;
    m_prev_cs   = spi_cs;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      tick(H);
      got[7-i] = spi_miso;
      spi_clk = 1'b1;
      tick(H);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    tick(H);
  endtask

  task automatic cs_high();
    tick(H);
    spi_cs = 1'b1;
    tick(2 * H + 2);
  endtask

  // Full byte with echo check against the model's last completed byte
  task automatic byte_io(input logic [7:0] b, output logic [7:0] got);
    logic [7:0] exp;
    exp = m_last;
    xfer(b, 8, got);
    check("miso_echo", {24'd0, got}, {24'd0, exp});
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    spi_cs = 1'b1;
    spi_clk = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [7:0] got;
    int v0;
    // Pins toggling under reset must not disturb anything
    for (int i = 0; i < 40; i++) begin
      spi_clk  = 1'($urandom_range(0, 1));
      spi_mosi = 1'($urandom_range(0, 1));
      spi_cs   = 1'($urandom_range(0, 1));
      tick(1);
    end
    do_reset();

    // Single byte after reset echoes the reset byte
    H = 8;
    v0 = vpulses;
    cs_low();
    byte_io(8'hA5, got);
    check("t2_miso", {24'd0, got}, 32'h3C);
    cs_high();
    check("t2_data", {24'd0, rx_data}, 32'hA5);
    check("t2_count", {16'd0, byte_count}, 32'd1);
    check("t2_pulses", vpulses - v0, 32'd1);

    // Aborted partial byte is discarded; the echo survives deselect
    cs_low();
    xfer(8'hFF, 5, got);
    cs_high();
    check("t4_count", {16'd0, byte_count}, 32'd1);
    cs_low();
    byte_io(8'h00, got);
    check("t4_miso", {24'd0, got}, 32'hA5);
    cs_high();
    check("t4_count2", {16'd0, byte_count}, 32'd2);

    // Three-byte burst after reset
    do_reset();
    v0 = vpulses;
    cs_low();
    byte_io(8'h12, got);
    check("t3_miso0", {24'd0, got}, 32'h3C);
    byte_io(8'h34, got);
    check("t3_miso1", {24'd0, got}, 32'h12);
    byte_io(8'h56, got);
    check("t3_miso2", {24'd0, got}, 32'h34);
    cs_high();
    check("t3_count", {16'd0, byte_count}, 32'd3);
    check("t3_pulses", vpulses - v0, 32'd3);

    // Reset in the middle of a byte
    cs_low();
    xfer(8'hC3, 4, got);
    do_reset();
    cs_low();
    byte_io(8'h77, got);
    check("t5_miso", {24'd0, got}, 32'h3C);
    cs_high();
    check("t5_data", {24'd0, rx_data}, 32'h77);
    check("t5_count", {16'd0, byte_count}, 32'd1);

    // Sixteen more bytes wrap the 4-bit counter to 1
    H = 4;
    cs_low();
    for (int i = 0; i < 16; i++) byte_io(8'(i * 17 + 3), got);
    cs_high();
    check("t6_count16", {16'd0, byte_count}, 32'd17);
    check("t6_count4", {28'd0, m4_count}, 32'd1);

    // Random bursts, speeds and aborts
    for (int t = 0; t < 15; t++) begin
      H = $urandom_range(4, 10);
      cs_low();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) byte_io(8'($urandom), got);
      if ($urandom_range(0, 2) == 0) xfer(8'($urandom), $urandom_range(1, 7), got);
      cs_high();
    end
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
